axo_wb_sched: RTL
=================

Name: axo_wb_sched

Overview:
- Write-back scheduler and register scoreboard for the single write port of the XLEN-bit register file.
- Arbitrates between two write-back requesters:
  - the execute stage (ALU, CSR read, JAL/JALR link);
  - the load-return path.
- Drives the register file write port from registered outputs.
- Tracks which destination registers have a write outstanding, and raises a decode stall on RAW/WAW hazards.

Parameters:
- XLEN, 32, register width.
- STARVE_LIMIT, 4, consecutive denied execute cycles before execute is forced ahead of load; 0 means load always has priority.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- flush  input  1  pipeline flush; clears the scoreboard.
- iss_valid  input  1  decode issues an instruction this cycle.
- iss_has_rs1, iss_has_rs2, iss_has_rd  input  1 each  register-presence flags from the register decoder.
- iss_rs1, iss_rs2, iss_rd  input  5 each  register indices of the issuing instruction.
- iss_stall  output  1  hazard; decode must hold.
- exe_valid  input  1  execute write-back request.
- exe_ready  output  1  execute request accepted this cycle.
- exe_rd  input  5  execute destination register.
- exe_data  input  XLEN  execute result.
- ld_valid  input  1  load write-back request.
- ld_ready  output  1  load request accepted this cycle.
- ld_rd  input  5  load destination register.
- ld_data  input  XLEN  load result.
- rf_we  output  1  register file write enable.
- rf_rd  output  5  register file write index.
- rf_din  output  XLEN  register file write data.

Behaviour:
- Reset (rst_n=0 at an edge): pending[31:1]=0, starve counter=0, rf_we=0, rf_rd=0, rf_din=0. While rst_n=0, exe_ready=0 and ld_ready=0. Reset mid-operation discards the output register and all pending bits.
- Arbitration is combinational from the current valids and the starve counter:
  - force = (STARVE_LIMIT!=0) && (cnt>=STARVE_LIMIT).
  - ld_ready = ld_valid && !(force && exe_valid).
  - exe_ready = exe_valid && !ld_ready.
  - At most one ready per cycle. A ready is never asserted without its matching valid.
- Requesters hold valid, rd and data stable until their ready is seen.
- Starve counter:
  - increments (saturating at STARVE_LIMIT) on each cycle with exe_valid && !exe_ready;
  - clears on exe_ready, or when exe_valid=0.
- Write latency is one cycle. A request accepted in cycle N appears on rf_we/rf_rd/rf_din during cycle N+1, and the register file commits at the end of N+1.
  - rf_we=1 only if the accepted rd!=0. rf_rd and rf_din still load on every accept.
  - With no accept in cycle N, rf_we=0 in cycle N+1 and rf_rd/rf_din hold their values.
- Scoreboard, for 5-bit index r in 1..31:
  - set: iss_valid && !iss_stall && iss_has_rd && iss_rd==r;
  - clear: rf_we && rf_rd==r, at the same edge as the register file write.
  - Simultaneous set and clear of the same r: set wins (newer producer).
  - Index 0 is never set.
- iss_stall = iss_valid && ((iss_has_rs1 && pend(iss_rs1)) || (iss_has_rs2 && pend(iss_rs2)) || (iss_has_rd && pend(iss_rd))).
  - pend(0) is 0.
  - No bypass: a register stays pending through the cycle in which rf_we writes it.
- flush: clears all pending bits at the edge, and overrides any set in that cycle.
  - Does not block or cancel arbitration or a write already in the output register.
  - Write-backs arriving after the flush still proceed to the register file.
- A write-back to a register that is not pending (for example, after a flush) is legal: it is written and nothing is cleared.

Decomposition:
- Shared axo_defines additions:
  - AXO_NREGS=32;
  - a write-back source encoding (WB_SRC_EXE=0, WB_SRC_LD=1), used by a debug-only source register alongside rf_rd.
- Sub-module axo_scoreboard: 31-bit pending vector with set, clear and flush ports, plus three lookup outputs.
- The arbiter, starve counter and output register stay in axo_wb_sched.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with exe_valid=ld_valid=1 -> both readies 0; after release rf_we=0 and iss_stall=0 for any query.
2. Single execute write: exe_valid=1, exe_rd=5, exe_data=32'hDEADBEEF in cycle N -> exe_ready=1 in N; in N+1 rf_we=1, rf_rd=5, rf_din=32'hDEADBEEF; in N+2 rf_we=0.
3. Contention: ld_valid and exe_valid both held high, STARVE_LIMIT=4 -> ld_ready for 4 cycles, exe_ready in the 5th, then ld_ready again. With STARVE_LIMIT=0 -> exe_ready never asserts while ld_valid=1.
4. RAW hazard: issue iss_rd=7, then issue iss_rs1=7 -> iss_stall=1 until the cycle after rf_we=1 with rf_rd=7, then 0. iss_rd=0 or iss_has_rs1=0 -> no stall.
5. Same-cycle set/clear: rf_we writes x9 while a new instruction issues with iss_rd=9 -> pending[9] stays 1, and the next query on rs2=9 stalls.
6. Flush: pending bits for x3 and x4 set, flush=1 for one cycle -> all stalls clear the next cycle. A later load write-back to x3 writes rf_din normally, with no stall effects.

Source files
------------

// File: rtl/axo_wb_sched_pkg.sv
// axo_wb_sched_pkg: shared constants and types for the
// write-back scheduler and its register scoreboard.
package axo_wb_sched_pkg;

  localparam int AXO_NREGS = 32;

  typedef enum logic {
    WB_SRC_EXE = 1'b0,
    WB_SRC_LD  = 1'b1
  } wb_src_e;

endpackage

// File: rtl/axo_scoreboard.sv
// axo_scoreboard: pending-write bit per architectural
// register, with set/clear/flush and three lookups.
module axo_scoreboard
  import axo_wb_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic [4:0] q1_idx,
  input  logic [4:0] q2_idx,
  input  logic [4:0] q3_idx,
  output logic       q1_hit,
  output logic       q2_hit,
  output logic       q3_hit
);

  logic [AXO_NREGS-1:1] pend_q;
  logic [AXO_NREGS-1:1] pend_d;
  logic [AXO_NREGS-1:0] vec;

  // x0 is hard-wired to never pending
  assign vec    = {pend_q, 1'b0};
  assign q1_hit = vec[q1_idx];
  assign q2_hit = vec[q2_idx];
  assign q3_hit = vec[q3_idx];

  // next pending vector; a set beats a same-cycle clear
  always_comb begin
    pend_d = '0;
    for (int r = 1; r < AXO_NREGS; r++) begin
      pend_d[r] = (set_en && set_idx == 5'(r)) ||
                  (pend_q[r] &&
                   !(clr_en && clr_idx == 5'(r)));
    end
  end

  // pending state; flush overrides any set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else if (flush) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/axo_wb_sched.sv
// axo_wb_sched: single-port register write-back arbiter
// with starvation guard and RAW/WAW decode stall.
module axo_wb_sched
  import axo_wb_sched_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            iss_valid,
  input  logic            iss_has_rs1,
  input  logic            iss_has_rs2,
  input  logic            iss_has_rd,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic [4:0]      iss_rd,
  output logic            iss_stall,
  input  logic            exe_valid,
  output logic            exe_ready,
  input  logic [4:0]      exe_rd,
  input  logic [XLEN-1:0] exe_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_din,
  output wb_src_e         dbg_src
);

  localparam int CW =
    (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0]   cnt_q;
  logic            frc;
  logic            acc;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            hit1;
  logic            hit2;
  logic            hitd;
  logic            iss_set;

  // load wins unless execute has waited long enough
  always_comb begin
    frc       = (STARVE_LIMIT != 0) && (cnt_q >= LIM);
    ld_ready  = rst_n && ld_valid && !(frc && exe_valid);
    exe_ready = rst_n && exe_valid && !ld_ready;
    acc       = ld_ready || exe_ready;
    sel_rd    = ld_ready ? ld_rd : exe_rd;
    sel_data  = ld_ready ? ld_data : exe_data;
  end

  // consecutive denied-execute counter, saturating
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (exe_valid && !exe_ready) begin
      if (cnt_q < LIM) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  // registered write port; x0 loads index/data but no we
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we   <= 1'b0;
      rf_rd   <= '0;
      rf_din  <= '0;
      dbg_src <= WB_SRC_EXE;
    end else if (acc) begin
      rf_we   <= (sel_rd != 5'd0);
      rf_rd   <= sel_rd;
      rf_din  <= sel_data;
      dbg_src <= ld_ready ? WB_SRC_LD : WB_SRC_EXE;
    end else begin
      rf_we   <= 1'b0;
    end
  end

  assign iss_stall = iss_valid &&
    ((iss_has_rs1 && hit1) ||
     (iss_has_rs2 && hit2) ||
     (iss_has_rd  && hitd));

  assign iss_set = iss_valid && !iss_stall && iss_has_rd;

  axo_scoreboard u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .set_en  (iss_set),
    .set_idx (iss_rd),
    .clr_en  (rf_we),
    .clr_idx (rf_rd),
    .q1_idx  (iss_rs1),
    .q2_idx  (iss_rs2),
    .q3_idx  (iss_rd),
    .q1_hit  (hit1),
    .q2_hit  (hit2),
    .q3_hit  (hitd)
  );

endmodule
